gf2m_digit_mult: RTL
====================

GF2M_DIGIT_MULT -- requirements
Module: gf2m_digit_mult

Interface
REQ-001 Parameter M, default 163: field degree and operand width.
REQ-002 Parameter POLY, default 163'hC9: low terms of the reduction polynomial f(x) = x^M + POLY (x^163+x^7+x^6+x^3+1).
REQ-003 Parameter D, default 1: digit size, i.e. operand-B bits consumed per cycle; legal range 1..M.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-007 Port abort  input  1  cancel the operation in progress; sampled only in RUN.
REQ-008 Port A  input  M  multiplicand, polynomial basis, bit i = coefficient of x^i.
REQ-009 Port B  input  M  multiplier, same encoding.
REQ-010 Port Z  output  M  registered product A*B mod f.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port done  output  1  one-cycle pulse; Z is valid and updated in the same cycle.

Function
REQ-013 FSM states are IDLE, RUN and DONE; encoding is free.
REQ-014 IDLE with start=1 at an edge: capture A into regA and B into regB, clear accumulator C, load counter with K = ceil(M/D), go to RUN.
REQ-015 A and B are sampled only at that edge; later changes do not affect the result.
REQ-016 Each RUN cycle processes j = 0..D-1 serially from the current regA: if regB[j] is set, C ^= a_j; then a_{j+1} = a_j*x mod f (left shift by 1; if the shifted-out bit is 1, XOR POLY).
REQ-017 At the end of each RUN cycle: regA <= a_D, regB <= regB >> D (zero-filled), counter decrements by 1.
REQ-018 In the last digit when D does not divide M, the zero-filled regB bits contribute nothing; no special case is needed.
REQ-019 RUN with counter = 1 at an edge: that edge processes the last digit and moves to DONE; Z <= final C on the same edge.
REQ-020 DONE lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
REQ-021 Latency: start accepted at edge t gives done=1 during the cycle after edge t+K; one result per K+2 cycles at maximum rate.
REQ-022 start is ignored in RUN and DONE; no queueing.
REQ-023 start is accepted again in the first IDLE cycle after DONE.
REQ-024 RUN with abort=1 at an edge: go to IDLE, no done, Z unchanged.
REQ-025 abort has priority over completion at the counter = 1 edge.
REQ-026 abort in IDLE or DONE has no effect.
REQ-027 Z holds its value from one completion until the next completion or reset.
REQ-028 Arithmetic is carry-free (XOR only); all intermediate values are M bits wide; the bit shifted out of position M-1 triggers reduction.

Reset
REQ-029 On rst: state=IDLE, busy=0, done=0, Z=0, regA=regB=C=0, counter=0, regardless of the clock.
REQ-030 rst asserted mid-RUN discards the operation; no done follows rst deassertion.
REQ-031 The first edge after rst deassertion with start=1 starts a new operation normally.

Verification
REQ-032 M=163, D=1: A=1, B=1, start pulse -> done exactly 164 cycles after the start edge, Z=1.
REQ-033 M=163, D=4: A=bit162 set, B=2 (x) -> Z=163'hC9, done 42 cycles after the start edge.
REQ-034 D in {1,3,8,163}: 200 random A,B pairs -> Z matches a software GF(2^163) reference.
REQ-035 A=B=0 -> Z=0; repeat with start held high continuously -> done pulses every K+2 cycles, busy low exactly one cycle between operations.
REQ-036 start pulsed mid-RUN with new operands -> ignored, Z matches the original operands.
REQ-037 abort at RUN cycle 5, and separately at the final RUN cycle -> no done, Z keeps its previous value.
REQ-038 rst pulse mid-RUN -> Z=0, busy=0 immediately (asynchronously), no done.

Source files
------------

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier: Z = A*B mod (x^M + POLY).
// Each RUN cycle consumes D bits of B (LSB first) while A is advanced by x^D.
module gf2m_digit_mult #(
    parameter int          M    = 163,
    parameter logic [M-1:0] POLY = 163'hC9,
    parameter int          D    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic [M-1:0] Z,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    // Handshake: start is taken only when busy=0 (IDLE); abort is honoured only
    // while running; done pulses for one cycle with Z already updated.
    localparam int K  = (M + D - 1) / D;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   rega_q, rega_d;
    logic [M-1:0]   regb_q, regb_d;
    logic [M-1:0]   c_q, c_d;
    logic [M-1:0]   z_q, z_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [M-1:0]   a_nx;
    logic [M-1:0]   c_nx;
    logic           last_digit;

    assign last_digit = (cnt_q == CW'(1));

    // One digit: D serial multiply-accumulate steps, each followed by a*x mod f.
    always_comb begin
        a_nx = rega_q;
        c_nx = c_q;
        for (int j = 0; j < D; j++) begin
            if (regb_q[j]) begin
                c_nx = c_nx ^ a_nx;
            end
            a_nx = {a_nx[M-2:0], 1'b0} ^ (a_nx[M-1] ? POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_digit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
        Z         = z_q;
    end

    always_comb begin
        rega_d = rega_q;
        regb_d = regb_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        z_d    = z_q;
        if (state_q == S_IDLE && start) begin
            rega_d = A;
            regb_d = B;
            c_d    = '0;
            cnt_d  = CW'(K);
        end else if (state_q == S_RUN && !abort) begin
            rega_d = a_nx;
            regb_d = regb_q >> D;
            c_d    = c_nx;
            cnt_d  = cnt_q - CW'(1);
            if (last_digit) begin
                z_d = c_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rega_q <= '0;
            regb_q <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            z_q    <= '0;
        end else begin
            rega_q <= rega_d;
            regb_q <= regb_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

endmodule
